// File: rtl/data_mem_if.sv
// Data-memory request/response bundle between the load/store unit (master)
// and the memory-side responder (slave).
interface data_mem_if;
  logic        cs;       // active-low chip select
  logic        wr;       // 0 = store, 1 = load
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        ready;
  logic        err;

  modport master (
    output cs, wr, addr, mask, data_wr,
    input  data_rd, ready, err
  );

  modport slave (
    input  cs, wr, addr, mask, data_wr,
    output data_rd, ready, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM with byte-lane writes, fixed access latency and a one-cycle ready pulse.
// Optional macro DMEM_ERR_EN: flag out-of-range addresses with err instead of wrapping the index.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     data_wr_q, data_wr_d;
  logic            oor_q, oor_d;
  logic [31:0]     data_rd_q, data_rd_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic [31:0]     rd_word;

  logic [31:0] mem [DEPTH];

  assign rd_word = mem[idx_q];

`ifdef DMEM_ERR_EN
  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];
`else
  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    data_wr_d = data_wr_q;
    oor_d     = oor_q;
    data_rd_d = data_rd_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.cs) begin
          wr_d      = bus.wr;
          idx_d     = bus.addr[AW+1:2];
          mask_d    = bus.mask;
          data_wr_d = bus.data_wr;
`ifdef DMEM_ERR_EN
          oor_d     = |bus.addr[31:AW+2];
`else
          oor_d     = 1'b0;
`endif
          cnt_d     = 4'(WAIT_CYCLES);
          state_d   = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        err_d   = oor_q;
        if (oor_q)      data_rd_d = 32'h0;
        else if (wr_q)  data_rd_d = rd_word;
        else            mem_we    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over the DONE edge, so an access caught by reset never completes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b1;
      idx_q     <= '0;
      mask_q    <= 4'd0;
      data_wr_q <= 32'h0;
      oor_q     <= 1'b0;
      data_rd_q <= 32'h0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      data_wr_q <= data_wr_d;
      oor_q     <= oor_d;
      data_rd_q <= data_rd_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the RAM array has no reset so it can map onto block RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= data_wr_q[8*i +: 8];
      end
    end
  end

  assign bus.data_rd = data_rd_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder; honours DMEM_ERR_EN when defined.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W     = 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_mem_if bus ();

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          ready_pulses = 0;
  exp_t        sb [$];
  logic [31:0] model_mem [int];
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      exp_t e;
      ready_pulses++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_ready observed=1 expected=0");
      end else begin
        e = sb.pop_front();
        check({e.tag, "_data"}, bus.data_rd, e.data);
        check({e.tag, "_err"}, {31'h0, bus.err}, {31'h0, e.err});
      end
    end
  end

  function automatic exp_t predict(input logic is_read, input logic [31:0] addr,
                                   input logic [3:0] mask, input logic [31:0] data,
                                   input string tag);
    exp_t        e;
    int          idx;
    logic        oor;
    logic [31:0] w;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DMEM_ERR_EN
    oor = (addr >= 32'(DEPTH * 4));
`else
    oor = 1'b0;
`endif
    e.tag = tag;
    e.err = oor;
    if (oor) begin
      e.data  = 32'h0;
      last_rd = 32'h0;
    end else if (is_read) begin
      e.data  = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      last_rd = e.data;
    end else begin
      w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
      model_mem[idx] = w;
      e.data = last_rd;
    end
    return e;
  endfunction

  task automatic drive(input logic is_read, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data);
    bus.cs      = 1'b0;
    bus.wr      = is_read;
    bus.addr    = addr;
    bus.mask    = mask;
    bus.data_wr = data;
  endtask

  // Counts falling edges until ready is seen; exp_k = W+2 means ready arrived W+1 edges after accept.
  task automatic wait_ready(input string tag, input int exp_k);
    int k    = 0;
    bit seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.ready === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_k));
  endtask

  // Called at a falling edge; returns at a falling edge with the DUT idle.
  task automatic do_access(input logic is_read, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data,
                           input string tag);
    sb.push_back(predict(is_read, addr, mask, data, tag));
    drive(is_read, addr, mask, data);
    @(posedge clk);
    #1 bus.cs = 1'b1;
    wait_ready(tag, W + 2);
    @(negedge clk);
    check({tag, "_pulse_width"}, {31'h0, bus.ready}, 32'h0);
  endtask

  initial begin
    int pulses_before;
    bus.cs      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 32'h0;
    bus.mask    = 4'h0;
    bus.data_wr = 32'h0;

    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data_rd", bus.data_rd, 32'h0);
    check("reset_ready", {31'h0, bus.ready}, 32'h0);
    check("reset_err", {31'h0, bus.err}, 32'h0);

    // Full-word write then read back
    do_access(1'b0, 32'h10, 4'b1111, 32'hDEAD_BEEF, "wr_full");
    do_access(1'b1, 32'h10, 4'b0000, 32'h0, "rd_full");

    // Single byte lane, then an empty mask
    do_access(1'b0, 32'h10, 4'b0100, 32'h00AA_0000, "wr_lane2");
    do_access(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, "rd_lane2");
    check("lane2_word", last_rd, 32'hDEAA_BEEF);
    do_access(1'b0, 32'h10, 4'b0000, 32'h1234_5678, "wr_mask0");
    do_access(1'b1, 32'h10, 4'b1111, 32'h0, "rd_mask0");

    // Mixed lanes on another word
    do_access(1'b0, 32'h20, 4'b1111, 32'h1111_1111, "wr_0x20");
    do_access(1'b0, 32'h24, 4'b1001, 32'hA5C3_3CA5, "wr_0x24_lanes");
    do_access(1'b1, 32'h24, 4'b0000, 32'h0, "rd_0x24");

    // Reset while in WAIT drops the write
    pulses_before = ready_pulses;
    drive(1'b0, 32'h20, 4'b1111, 32'h2222_2222);
    @(posedge clk);
    #1 bus.cs = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wait_no_ready", 32'(ready_pulses - pulses_before), 32'h0);
    check("rst_wait_data_rd", bus.data_rd, 32'h0);
    last_rd = 32'h0;

    // Reset on the DONE edge drops the write
    drive(1'b0, 32'h20, 4'b1111, 32'h3333_3333);
    @(posedge clk);
    #1 bus.cs = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_done_no_ready", 32'(ready_pulses - pulses_before), 32'h0);
    do_access(1'b1, 32'h20, 4'b0000, 32'h0, "rd_after_rst");

    // Inputs change after accept; cs held low so a second read is taken one idle cycle later
    sb.push_back(predict(1'b1, 32'h10, 4'b0000, 32'h0, "rd_latched"));
    drive(1'b1, 32'h10, 4'b0000, 32'h0);
    @(posedge clk);
    #1 drive(1'b1, 32'h20, 4'b1111, 32'hFFFF_FFFF);
    wait_ready("rd_latched", W + 2);
    sb.push_back(predict(1'b1, 32'h20, 4'b0000, 32'h0, "rd_held_cs"));
    wait_ready("rd_held_cs", W + 2);
    bus.cs = 1'b1;
    @(negedge clk);

    // Out-of-range store: flagged with err, or wrapped onto word 1
    do_access(1'b0, 32'h4, 4'b1111, 32'h4444_4444, "wr_0x4");
    do_access(1'b0, 32'h1004, 4'b1111, 32'hCAFE_F00D, "wr_oor");
    do_access(1'b1, 32'h4, 4'b0000, 32'h0, "rd_0x4");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
